dmem_arbiter: RTL and testbench

Single-port data-memory arbiter between the pipeline Memory stage (LW/SW) and a host/debug port used for program loading and result readback such as word 0. It decides one access per cycle, registers the winning command onto the 256-word data memory, and returns read data with a per-requester valid pulse. The pipeline has priority. An optional starvation guard forces a host slot.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: pipeline Memory stage has priority over the host/debug port.
// Optional starvation guard for the host is enabled with `define DMEM_FAIR_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    // pipeline Memory stage
    input  logic              p_req,
    input  logic              p_we,
    input  logic [15:0]       p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_rvalid,
    output logic              p_err,
    // host / debug port
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvalid,
    // data memory
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    // Last-grant state; the next state doubles as this cycle's arbitration winner.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PIPE = 2'd1,
        ST_HOST = 2'd2
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] p_word;
    logic              p_illegal;
    logic              force_host;
    logic              rd_pend;
    logic              rd_src;      // 1: read belongs to the host
    logic [DATA_W-1:0] p_rdata_q;
    logic [DATA_W-1:0] h_rdata_q;

    assign p_word    = p_addr[ADDR_W+1:2];
    assign p_illegal = (p_addr[1:0] != 2'b00) || ((p_addr >> (ADDR_W + 2)) != 16'd0);

`ifdef DMEM_FAIR_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;

    assign force_host = h_req && (wait_cnt == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!h_req || h_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign force_host = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state = ST_IDLE;
        p_stall    = 1'b0;
        h_gnt      = 1'b0;
        if (force_host) begin
            next_state = ST_HOST;
        end else if (p_req) begin
            next_state = ST_PIPE;
        end else if (h_req) begin
            next_state = ST_HOST;
        end
        // Handshakes are held low while in reset so nothing looks accepted.
        p_stall = reset_n && p_req && (next_state != ST_PIPE);
        h_gnt   = reset_n && h_req && (next_state == ST_HOST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            p_err   <= 1'b0;
        end else begin
            state <= next_state;
            m_en  <= 1'b0;
            p_err <= 1'b0;
            case (next_state)
                ST_PIPE: begin
                    if (p_illegal) begin
                        p_err <= 1'b1;
                    end else begin
                        m_en    <= 1'b1;
                        m_we    <= p_we;
                        m_addr  <= p_word;
                        m_wdata <= p_wdata;
                    end
                end
                ST_HOST: begin
                    m_en    <= 1'b1;
                    m_we    <= h_we;
                    m_addr  <= h_addr;
                    m_wdata <= h_wdata;
                end
                default: ;
            endcase
        end
    end

    // The read tag trails the command by one cycle to line up with m_rdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend   <= 1'b0;
            rd_src    <= 1'b0;
            p_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            rd_pend   <= m_en && !m_we;
            rd_src    <= (state == ST_HOST);
            p_rdata_q <= p_rdata;
            h_rdata_q <= h_rdata;
        end
    end

    assign p_rvalid = rd_pend && !rd_src;
    assign h_rvalid = rd_pend && rd_src;
    assign p_rdata  = p_rvalid ? m_rdata : p_rdata_q;
    assign h_rdata  = h_rvalid ? m_rdata : h_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a rule-level model predicts grants, memory commands,
// errors and read returns; a negedge monitor compares them against the DUT.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              p_req = 1'b0, p_we = 1'b0;
    logic [15:0]       p_addr = '0;
    logic [DATA_W-1:0] p_wdata = '0;
    logic              p_stall, p_rvalid, p_err;
    logic [DATA_W-1:0] p_rdata;
    logic              h_req = 1'b0, h_we = 1'b0;
    logic [ADDR_W-1:0] h_addr = '0;
    logic [DATA_W-1:0] h_wdata = '0;
    logic              h_gnt, h_rvalid;
    logic [DATA_W-1:0] h_rdata;
    logic              m_en, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata = '0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid), .p_err(p_err),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory attached to the arbiter.
    logic [DATA_W-1:0] dut_mem [256];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) dut_mem[m_addr] <= m_wdata;
            else      m_rdata <= dut_mem[m_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                due;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_exp_t;

    typedef struct {
        int                due;
        logic              host;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    cmd_exp_t cmd_q [$];
    rd_exp_t  rd_q  [$];
    int       err_q [$];

    logic [DATA_W-1:0] model_mem [256];
`ifdef DMEM_FAIR_EN
    int model_cnt = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of requests, predict the arbitration and queue the expected effects.
    task automatic step(input logic pr, input logic pw, input logic [15:0] pa, input logic [31:0] pd,
                        input logic hr, input logic hw, input logic [7:0] ha, input logic [31:0] hd,
                        output logic p_acc, output logic h_acc);
        logic       illegal, force_h, pipe_win, host_win;
        logic [7:0] pword;
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        illegal = (pa[1:0] != 2'b00) || (pa[15:10] != 6'd0);
        pword   = pa[9:2];
        force_h = 1'b0;
`ifdef DMEM_FAIR_EN
        force_h = hr && (model_cnt == MAX_WAIT);
`endif
        pipe_win = reset_n && pr && !force_h;
        host_win = reset_n && hr && !pipe_win;
        @(negedge clk);
        check("p_stall", p_stall, reset_n && pr && !pipe_win);
        check("h_gnt", h_gnt, host_win);
        if (pipe_win) begin
            if (illegal) begin
                err_q.push_back(cyc + 1);
            end else begin
                cmd_q.push_back('{due: cyc + 1, we: pw, addr: pword, wdata: pd});
                if (pw) model_mem[pword] = pd;
                else    rd_q.push_back('{due: cyc + 2, host: 1'b0, data: model_mem[pword]});
            end
        end
        if (host_win) begin
            cmd_q.push_back('{due: cyc + 1, we: hw, addr: ha, wdata: hd});
            if (hw) model_mem[ha] = hd;
            else    rd_q.push_back('{due: cyc + 2, host: 1'b1, data: model_mem[ha]});
        end
`ifdef DMEM_FAIR_EN
        if (!reset_n || !hr || host_win) model_cnt = 0;
        else if (model_cnt < MAX_WAIT)    model_cnt++;
`endif
        p_acc = pipe_win;
        h_acc = host_win;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic pa_ok, ha_ok;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, pa_ok, ha_ok);
    endtask

    // Monitor: pops the scoreboard when an expectation falls due and checks everything else is quiet.
    logic [DATA_W-1:0] last_p = '0;
    logic [DATA_W-1:0] last_h = '0;

    always @(negedge clk) begin : monitor
        cmd_exp_t c;
        rd_exp_t  r;
        logic     exp_en, exp_err, exp_rv, exp_host;
        if (!reset_n) begin
            cmd_q.delete();
            rd_q.delete();
            err_q.delete();
            last_p = '0;
            last_h = '0;
        end
        exp_en = (cmd_q.size() > 0) && (cmd_q[0].due == cyc);
        check("m_en", m_en, exp_en);
        if (exp_en) begin
            c = cmd_q.pop_front();
            check("m_we", m_we, c.we);
            check("m_addr", m_addr, c.addr);
            if (c.we) check("m_wdata", m_wdata, c.wdata);
        end
        exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
        check("p_err", p_err, exp_err);
        if (exp_err) void'(err_q.pop_front());
        exp_rv   = (rd_q.size() > 0) && (rd_q[0].due == cyc);
        exp_host = 1'b0;
        if (exp_rv) begin
            r        = rd_q.pop_front();
            exp_host = r.host;
            if (r.host) last_h = r.data;
            else        last_p = r.data;
        end
        check("p_rvalid", p_rvalid, exp_rv && !exp_host);
        check("h_rvalid", h_rvalid, exp_rv && exp_host);
        check("p_rdata", p_rdata, last_p);
        check("h_rdata", h_rdata, last_h);
    end

    initial begin : stim
        logic        pa_ok, ha_ok, gnt_seen;
        logic        rp, rpw, rh, rhw;
        logic [15:0] rpa;
        logic [31:0] rpd, rhd;
        logic [7:0]  rha;

        // Reset: handshakes stay low even with both requesters active.
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b0, 16'h0004, 32'h0, 1'b1, 1'b0, 8'h01, 32'h0, pa_ok, ha_ok);
        check("reset m_we", m_we, 1'b0);
        check("reset m_addr", m_addr, 8'h00);
        check("reset m_wdata", m_wdata, 32'h0);
        reset_n = 1'b1;

        // Preload words 0..15 through the host port.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 8'(i), $urandom, pa_ok, ha_ok);
        idle(2);

        // Pipeline SW then LW of the same word, back to back.
        step(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 8'h0, 32'h0, pa_ok, ha_ok);
        step(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, pa_ok, ha_ok);
        idle(3);

        // Misaligned and out-of-range pipeline accesses are dropped with an error pulse.
        step(1'b1, 1'b0, 16'h0006, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, pa_ok, ha_ok);
        idle(1);
        step(1'b1, 1'b0, 16'h0400, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, pa_ok, ha_ok);
        idle(2);

        // Host write then read of word 0.
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 8'h00, 32'h55, pa_ok, ha_ok);
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0, pa_ok, ha_ok);
        idle(3);

        // Sustained contention: the model decides whether the host ever gets a slot.
        gnt_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 16'h0008, 32'h0, 1'b1, 1'b0, 8'h03, 32'h0, pa_ok, ha_ok);
            gnt_seen = gnt_seen | ha_ok;
        end
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 8'h03, 32'h0, pa_ok, ha_ok);
        idle(3);

        // Reset the cycle after a pipeline LW is granted; its read must never return.
        step(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, pa_ok, ha_ok);
        reset_n = 1'b0;
        p_req   = 1'b0;
        #1;
        check("mid-reset m_en", m_en, 1'b0);
        check("mid-reset p_rvalid", p_rvalid, 1'b0);
        check("mid-reset p_stall", p_stall, 1'b0);
        idle(2);
`ifdef DMEM_FAIR_EN
        model_cnt = 0;
`endif
        reset_n = 1'b1;
        idle(4);

        // Alternating pipeline (word 1) and host (word 2) reads, then an overlapping pair.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b0, 16'h0004, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, pa_ok, ha_ok);
            else            step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, pa_ok, ha_ok);
        end
        step(1'b1, 1'b0, 16'h0004, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, pa_ok, ha_ok);
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, pa_ok, ha_ok);
        idle(3);

        // Randomised traffic honouring both hold protocols; host may withdraw before a grant.
        rp = 1'b0; rh = 1'b0;
        rpw = 1'b0; rhw = 1'b0; rpa = '0; rpd = '0; rha = '0; rhd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!rp && ($urandom_range(2, 0) != 0)) begin
                rp  = 1'b1;
                rpw = 1'($urandom_range(1, 0));
                rpd = $urandom;
                if ($urandom_range(15, 0) == 0) rpa = 16'($urandom);
                else                            rpa = {6'd0, 8'($urandom_range(15, 0)), 2'b00};
            end
            if (!rh && ($urandom_range(3, 0) == 0)) begin
                rh  = 1'b1;
                rhw = 1'($urandom_range(1, 0));
                rha = 8'($urandom_range(15, 0));
                rhd = $urandom;
            end else if (rh && ($urandom_range(31, 0) == 0)) begin
                rh = 1'b0;
            end
            step(rp, rpw, rpa, rpd, rh, rhw, rha, rhd, pa_ok, ha_ok);
            if (pa_ok) rp = 1'b0;
            if (ha_ok) rh = 1'b0;
        end
        idle(4);

        check("scoreboard drained", 64'(cmd_q.size() + rd_q.size() + err_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
